exception_coprocessor: RTL
==========================

# exception_coprocessor

Parametrised exception/interrupt coprocessor sitting beside the core datapath. Latches overflow and bad-address faults plus `NUM_IRQ` external interrupt lines, arbitrates them by fixed priority, and runs a request/acknowledge trap handshake with the control unit. On an accepted trap it captures EPC, cause and `NUM_SAVE` register backups, and enters handler mode. A one-cycle `eret` pulse restores the backups and returns to user mode.

## Interface
- `DATA_W`, 16, width of PC, EPC and each saved register
- `NUM_IRQ`, 4, number of external interrupt lines (1..8)
- `NUM_SAVE`, 2, number of backed-up registers (1..4)
- `VECTOR_BASE`, 16'h0100, handler entry address
- `CAUSE_W`, 4, cause field width (must hold `NUM_IRQ+2`)

Ports:
- `clock`  in  1  single clock, all state updates on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `overflow`  in  1  ALU overflow fault, one-cycle pulse
- `bad_addr`  in  1  bad memory address fault, one-cycle pulse
- `irq`  in  NUM_IRQ  level interrupt lines
- `fault_pc`  in  DATA_W  PC to record as EPC, valid every cycle
- `save_in`  in  NUM_SAVE*DATA_W  live register values to back up
- `ie_set` / `ie_clr`  in  1  software enable/disable of interrupts
- `trap_ack`  in  1  core accepts trap this cycle
- `eret`  in  1  return-from-exception pulse
- `trap_req`  out  1  trap pending toward core
- `epc`  out  DATA_W  captured PC
- `cause`  out  CAUSE_W  captured cause code
- `mode`  out  1  0 = user, 1 = handler
- `ie`  out  1  interrupts enabled
- `pending`  out  NUM_IRQ  latched, untaken interrupts
- `save_out`  out  NUM_SAVE*DATA_W  backed-up values
- `restore_valid`  out  1  `save_out`/`epc` to be written back this cycle
- `handler_addr`  out  DATA_W  jump target for the trap

## Operation
- Cause codes: 0 none, 1 overflow, 2 bad address, 3+i for `irq[i]`.
- Priority: overflow > bad_addr > irq[0] > … > irq[NUM_IRQ-1]. Resolves the simultaneous-event case.
- Fault pulses set sticky flags. `irq[i]` high sets `pending[i]`. Flags and pending bits clear only when that source is taken, or on reset.
- Faults are taken regardless of `ie`. Interrupts are taken only when `ie`=1.
- States:
  - IDLE: if any takeable source exists, latch the winning cause into a request register and go to REQ.
  - REQ: hold `trap_req`=1 with a stable cause. The cause is frozen: later, higher-priority events stay pending and do not preempt. On `trap_ack`: epc←`fault_pc`, `cause`←request, `save_out`←`save_in`, `mode`←1, prior ie saved and `ie`←0, taken source cleared, go to HANDLER.
  - HANDLER: new events only latch. On `eret`: `restore_valid`=1 for one cycle, `mode`←0, `ie`←saved ie, go to IDLE.
- `ie_set` and `ie_clr` in the same cycle: clear wins. In HANDLER both are ignored.
- `eret` outside HANDLER, or `trap_ack` outside REQ: ignored.

## Timing
- Reset (`reset_n`=0 at a clock edge), from any state mid-operation:
  - state IDLE
  - all outputs 0: `epc`, `cause`, `mode`, `ie`, `pending`, `save_out`, `trap_req`, `restore_valid`
  - `handler_addr`=`VECTOR_BASE`
  - all flags cleared
- Source latch: one cycle. An event at edge N is visible in `pending` or the flags after edge N.
- `trap_req` rises one cycle after the source is latched, giving 2 cycles from a pulse to the request.
- `trap_ack` sampled while `trap_req`=1. `trap_req` drops the cycle after ack. `mode`=1 and `epc`/`cause` are valid the cycle after ack.
- `restore_valid` is high exactly the cycle after `eret`.
- An event pending at `eret` can raise `trap_req` at the earliest 1 cycle after returning to IDLE.
- `epc`, `cause` and `save_out` hold their values until the next accepted trap.

## Configuration
- `COPROC_VECTOR_EN` defined: `handler_addr` = `VECTOR_BASE` + (cause×4), updated with `cause`.
- `COPROC_VECTOR_EN` undefined: `handler_addr` is constant `VECTOR_BASE`.

## Test plan
- Reset mid-HANDLER with epc=0x1234 → next cycle all outputs 0, `handler_addr`=0x0100, `trap_req`=0.
- `ie`=0, `overflow` pulse with `fault_pc`=0x0042 → `trap_req` 2 cycles later. Ack → epc=0x0042, cause=1, mode=1.
- `overflow`, `bad_addr` and `irq[1]` in the same cycle, `ie`=1 → cause=1 first. After `eret`: cause=2. Next: cause=4. Three traps total.
- `irq[0]` with `ie`=0 → `pending`=4'b0001, no `trap_req`. `ie_set` → `trap_req` the next cycle, cause=3.
- Trap with `save_in`={0xAAAA,0x5555}; `save_in` changes during handler; `eret` → `restore_valid`=1 for one cycle with `save_out`={0xAAAA,0x5555}, mode=0, ie restored to 1.
- With `COPROC_VECTOR_EN`, `bad_addr` trap → `handler_addr`=0x0108. Without it → 0x0100.

Source files
------------

// File: rtl/exception_coprocessor.sv
// Exception/interrupt coprocessor: latches faults and IRQs, runs a trap handshake.
// Optional macro COPROC_VECTOR_EN: handler_addr = VECTOR_BASE + cause*4 when defined.
//
// Ports:
//   clock, reset_n       - clock, synchronous active-low reset
//   overflow, bad_addr   - fault pulses (sticky until taken)
//   irq                  - level interrupt lines, latched into pending
//   fault_pc, save_in    - values captured on an accepted trap
//   ie_set, ie_clr       - interrupt enable control (clear wins)
//   trap_ack, eret       - trap accept / return-from-exception
//   trap_req, epc, cause, mode, ie, pending, save_out,
//   restore_valid, handler_addr - status and captured state
module exception_coprocessor #(
    parameter int                 DATA_W      = 16,
    parameter int                 NUM_IRQ     = 4,
    parameter int                 NUM_SAVE    = 2,
    parameter logic [DATA_W-1:0]  VECTOR_BASE = DATA_W'(16'h0100),
    parameter int                 CAUSE_W     = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         overflow,
    input  logic                         bad_addr,
    input  logic [NUM_IRQ-1:0]           irq,
    input  logic [DATA_W-1:0]            fault_pc,
    input  logic [NUM_SAVE*DATA_W-1:0]   save_in,
    input  logic                         ie_set,
    input  logic                         ie_clr,
    input  logic                         trap_ack,
    input  logic                         eret,
    output logic                         trap_req,
    output logic [DATA_W-1:0]            epc,
    output logic [CAUSE_W-1:0]           cause,
    output logic                         mode,
    output logic                         ie,
    output logic [NUM_IRQ-1:0]           pending,
    output logic [NUM_SAVE*DATA_W-1:0]   save_out,
    output logic                         restore_valid,
    output logic [DATA_W-1:0]            handler_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HANDLER
    } state_t;

    state_t               state;
    logic                 ovf_flag;
    logic                 bad_flag;
    logic                 saved_ie;
    logic [CAUSE_W-1:0]   req_cause;

    logic                 win_valid;
    logic [CAUSE_W-1:0]   win_cause;
    logic                 take;
    logic                 clr_ovf;
    logic                 clr_bad;
    logic [NUM_IRQ-1:0]   clr_irq;

    // Fixed priority: scan from lowest priority up so the highest wins last.
    always_comb begin
        win_valid = 1'b0;
        win_cause = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i] && ie) begin
                win_valid = 1'b1;
                win_cause = CAUSE_W'(i + 3);
            end
        end
        if (bad_flag) begin
            win_valid = 1'b1;
            win_cause = CAUSE_W'(2);
        end
        if (ovf_flag) begin
            win_valid = 1'b1;
            win_cause = CAUSE_W'(1);
        end
    end

    // Only the source named by the frozen request is cleared on accept.
    always_comb begin
        take    = (state == S_REQ) && trap_ack;
        clr_ovf = take && (req_cause == CAUSE_W'(1));
        clr_bad = take && (req_cause == CAUSE_W'(2));
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_irq[i] = take && (req_cause == CAUSE_W'(i + 3));
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            ovf_flag      <= 1'b0;
            bad_flag      <= 1'b0;
            pending       <= '0;
            saved_ie      <= 1'b0;
            req_cause     <= '0;
            trap_req      <= 1'b0;
            epc           <= '0;
            cause         <= '0;
            mode          <= 1'b0;
            ie            <= 1'b0;
            save_out      <= '0;
            restore_valid <= 1'b0;
`ifdef COPROC_VECTOR_EN
            handler_addr  <= VECTOR_BASE;
`endif
        end else begin
            restore_valid <= 1'b0;
            // A new event in the same cycle as its clear re-arms the source.
            ovf_flag      <= (ovf_flag & ~clr_ovf) | overflow;
            bad_flag      <= (bad_flag & ~clr_bad) | bad_addr;
            pending       <= (pending & ~clr_irq) | irq;

            if (state != S_HANDLER) begin
                if (ie_clr) begin
                    ie <= 1'b0;
                end else if (ie_set) begin
                    ie <= 1'b1;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        req_cause <= win_cause;
                        trap_req  <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (trap_ack) begin
                        trap_req <= 1'b0;
                        epc      <= fault_pc;
                        cause    <= req_cause;
                        save_out <= save_in;
                        mode     <= 1'b1;
                        saved_ie <= ie;
                        ie       <= 1'b0;
                        state    <= S_HANDLER;
`ifdef COPROC_VECTOR_EN
                        handler_addr <= VECTOR_BASE
                                      + (DATA_W'(req_cause) << 2);
`endif
                    end
                end
                S_HANDLER: begin
                    if (eret) begin
                        restore_valid <= 1'b1;
                        mode          <= 1'b0;
                        ie            <= saved_ie;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef COPROC_VECTOR_EN
    assign handler_addr = VECTOR_BASE;
`endif

endmodule
